// File: rtl/pong_pkg.sv
// pong_pkg: screen/paddle/ball geometry shared with the VGA side and the game FSM state encoding.
// Exports: geometry and timing constants, state_t (IDLE, SERVE, PLAY, POINT, OVER).
package pong_pkg;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int PAD_H        = 64;
    localparam int PAD_W        = 8;
    localparam int PAD1_X       = 16;
    localparam int PAD2_X       = 616;
    localparam int BALL_SZ      = 8;
    localparam int PAD_STEP     = 4;
    localparam int BALL_STEP    = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: control inputs and game-state outputs of the pong controller.
// master: drives iFRAME_TICK, buttons and sw; observes positions, scores, game_over, state.
// slave:  the controller side of the same signals.
interface pong_game_ctrl_if;
    logic       iFRAME_TICK;
    logic       up1;
    logic       down1;
    logic       up2;
    logic       down2;
    logic       sw;
    logic [8:0] pad1_y;
    logic [8:0] pad2_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output iFRAME_TICK, up1, down1, up2, down2, sw,
        input  pad1_y, pad2_y, ball_x, ball_y, score1, score2, game_over, state
    );
    modport slave (
        input  iFRAME_TICK, up1, down1, up2, down2, sw,
        output pad1_y, pad2_y, ball_x, ball_y, score1, score2, game_over, state
    );
endinterface

// File: rtl/pong_btn_sync.sv
// pong_btn_sync: two-flop synchronizer for W asynchronous inputs.
// Ports: clk, rst_n (async active-low), d (async inputs), q (synchronized outputs).
module pong_btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            q <= '0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-stepped pong game logic (paddles, ball physics, scoring, game FSM).
// Ports: iVGA_CLK pixel clock, iRST_n async active-low reset,
//        bus (slave) carrying iFRAME_TICK, buttons, sw and the registered game-state outputs.
module pong_game_ctrl #(
    parameter int H_RES        = pong_pkg::H_RES,
    parameter int V_RES        = pong_pkg::V_RES,
    parameter int PAD_H        = pong_pkg::PAD_H,
    parameter int PAD_W        = pong_pkg::PAD_W,
    parameter int PAD1_X       = pong_pkg::PAD1_X,
    parameter int PAD2_X       = pong_pkg::PAD2_X,
    parameter int BALL_SZ      = pong_pkg::BALL_SZ,
    parameter int PAD_STEP     = pong_pkg::PAD_STEP,
    parameter int BALL_STEP    = pong_pkg::BALL_STEP,
    parameter int SERVE_FRAMES = pong_pkg::SERVE_FRAMES,
    parameter int WIN_SCORE    = pong_pkg::WIN_SCORE
) (
    input logic             iVGA_CLK,
    input logic             iRST_n,
    pong_game_ctrl_if.slave bus
);
    import pong_pkg::*;

    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic signed [10:0] XC    = 11'((H_RES - BALL_SZ) / 2);
    localparam logic signed [10:0] YC    = 11'((V_RES - BALL_SZ) / 2);
    localparam logic signed [10:0] PC    = 11'((V_RES - PAD_H) / 2);
    localparam logic signed [10:0] PMAX  = 11'(V_RES - PAD_H);
    localparam logic signed [10:0] XMAX  = 11'(H_RES - BALL_SZ);
    localparam logic signed [10:0] YMAX  = 11'(V_RES - BALL_SZ);
    localparam logic signed [10:0] LF    = 11'(PAD1_X + PAD_W);
    localparam logic signed [10:0] RF    = 11'(PAD2_X);
    localparam logic signed [10:0] BSZ   = 11'(BALL_SZ);
    localparam logic signed [10:0] PH    = 11'(PAD_H);
    localparam logic signed [10:0] BSTEP = 11'(BALL_STEP);
    localparam logic signed [10:0] PSTEP = 11'(PAD_STEP);

    logic up1, down1, up2, down2, sw;

    pong_btn_sync #(.W(5)) u_sync (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .d     ({bus.up1, bus.down1, bus.up2, bus.down2, bus.sw}),
        .q     ({up1, down1, up2, down2, sw})
    );

    state_t             st_q, st_d;
    logic [8:0]         pad1_q, pad1_d, pad2_q, pad2_d, by_q, by_d;
    logic [9:0]         bx_q, bx_d;
    logic [3:0]         s1_q, s1_d, s2_q, s2_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               vxn_q, vxn_d, vyn_q, vyn_d;
    logic signed [10:0] bxs, bys, p1s, p2s, nx, ny;
    logic               hit_l, hit_r, serve_done;

    // Up and down together cancel; result saturates to the playfield.
    function automatic logic [8:0] pad_next(input logic [8:0] p, input logic u, input logic d);
        logic signed [10:0] n;
        n = $signed({2'b00, p}) + ((u && !d) ? -PSTEP : (d && !u) ? PSTEP : 11'sd0);
        return n < 11'sd0 ? 9'd0 : n > PMAX ? 9'(PMAX) : n[8:0];
    endfunction

    always_comb begin
        bxs        = $signed({1'b0, bx_q});
        bys        = $signed({2'b00, by_q});
        p1s        = $signed({2'b00, pad1_q});
        p2s        = $signed({2'b00, pad2_q});
        nx         = bxs + (vxn_q ? -BSTEP : BSTEP);
        ny         = bys + (vyn_q ? -BSTEP : BSTEP);
        // Face crossings are tested against pre-move paddle positions.
        hit_l      = vxn_q && nx <= LF && bxs >= LF && bys + BSZ > p1s && bys < p1s + PH;
        hit_r      = !vxn_q && nx + BSZ >= RF && bxs + BSZ <= RF && bys + BSZ > p2s && bys < p2s + PH;
        serve_done = cnt_q == CW'(SERVE_FRAMES - 1);
        st_d       = st_q;
        pad1_d     = pad1_q;
        pad2_d     = pad2_q;
        bx_d       = bx_q;
        by_d       = by_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        cnt_d      = cnt_q;
        vxn_d      = vxn_q;
        vyn_d      = vyn_q;
        if (bus.iFRAME_TICK) begin
            case (st_q)
                // IDLE is only entered with centred positions and cleared scores.
                IDLE: st_d = sw ? SERVE : IDLE;
                SERVE: if (sw) begin
                    pad1_d = pad_next(pad1_q, up1, down1);
                    pad2_d = pad_next(pad2_q, up2, down2);
                    cnt_d  = serve_done ? '0 : cnt_q + CW'(1);
                    st_d   = serve_done ? PLAY : SERVE;
                end
                PLAY: if (sw) begin
                    pad1_d = pad_next(pad1_q, up1, down1);
                    pad2_d = pad_next(pad2_q, up2, down2);
                    by_d   = ny < 11'sd0 ? 9'd0 : ny > YMAX ? 9'(YMAX) : ny[8:0];
                    vyn_d  = ny < 11'sd0 ? 1'b0 : ny > YMAX ? 1'b1 : vyn_q;
                    if (hit_l) begin
                        bx_d  = 10'(LF);
                        vxn_d = 1'b0;
                    end else if (hit_r) begin
                        bx_d  = 10'(RF - BSZ);
                        vxn_d = 1'b1;
                    end else if (nx <= 11'sd0) begin
                        // Next serve heads back toward the player who missed.
                        bx_d  = '0;
                        s2_d  = s2_q + 4'd1;
                        vxn_d = 1'b1;
                        vyn_d = 1'b0;
                        st_d  = POINT;
                    end else if (nx >= XMAX) begin
                        bx_d  = 10'(XMAX);
                        s1_d  = s1_q + 4'd1;
                        vxn_d = 1'b0;
                        vyn_d = 1'b0;
                        st_d  = POINT;
                    end else begin
                        bx_d  = nx[9:0];
                    end
                end
                POINT: if (s1_q == 4'(WIN_SCORE) || s2_q == 4'(WIN_SCORE)) begin
                    st_d = OVER;
                end else begin
                    st_d = SERVE;
                    bx_d = 10'(XC);
                    by_d = 9'(YC);
                end
                OVER: if (!sw) begin
                    st_d   = IDLE;
                    pad1_d = 9'(PC);
                    pad2_d = 9'(PC);
                    bx_d   = 10'(XC);
                    by_d   = 9'(YC);
                    s1_d   = '0;
                    s2_d   = '0;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            st_q   <= IDLE;
            pad1_q <= 9'(PC);
            pad2_q <= 9'(PC);
            bx_q   <= 10'(XC);
            by_q   <= 9'(YC);
            s1_q   <= '0;
            s2_q   <= '0;
            cnt_q  <= '0;
            vxn_q  <= 1'b0;
            vyn_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            pad1_q <= pad1_d;
            pad2_q <= pad2_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            vxn_q  <= vxn_d;
            vyn_q  <= vyn_d;
        end
    end

    assign bus.pad1_y    = pad1_q;
    assign bus.pad2_y    = pad2_q;
    assign bus.ball_x    = bx_q;
    assign bus.ball_y    = by_q;
    assign bus.score1    = s1_q;
    assign bus.score2    = s2_q;
    assign bus.state     = st_q;
    assign bus.game_over = st_q == OVER;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl.
// Plays a scripted game whose ball trajectory and scores are worked out by hand.
module tb_pong_game_ctrl;
    localparam int ST_IDLE  = 0;
    localparam int ST_SERVE = 1;
    localparam int ST_PLAY  = 2;
    localparam int ST_POINT = 3;
    localparam int ST_OVER  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int s);
        chk({tag, ".state"}, 32'(bus.state), s);
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, ".ball_x"}, 32'(bus.ball_x), x);
        chk({tag, ".ball_y"}, 32'(bus.ball_y), y);
    endtask

    task automatic chk_pads(input string tag, input int p1, input int p2);
        chk({tag, ".pad1_y"}, 32'(bus.pad1_y), p1);
        chk({tag, ".pad2_y"}, 32'(bus.pad2_y), p2);
    endtask

    task automatic chk_score(input string tag, input int a, input int b);
        chk({tag, ".score1"}, 32'(bus.score1), a);
        chk({tag, ".score2"}, 32'(bus.score2), b);
    endtask

    task automatic chk_reset(input string tag);
        chk_st(tag, ST_IDLE);
        chk_pads(tag, 208, 208);
        chk_ball(tag, 316, 236);
        chk_score(tag, 0, 0);
        chk({tag, ".game_over"}, 32'(bus.game_over), 0);
    endtask

    // Three idle clocks let freshly set buttons clear the synchronizer before the tick.
    task automatic tick();
        repeat (3) @(negedge clk);
        bus.iFRAME_TICK = 1'b1;
        @(negedge clk);
        bus.iFRAME_TICK = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bus.iFRAME_TICK = 1'b0;
        bus.up1 = 1'b0;
        bus.down1 = 1'b0;
        bus.up2 = 1'b0;
        bus.down2 = 1'b0;
        bus.sw = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        tick();
        chk_st("idle_sw0", ST_IDLE);

        // Serve with both paddles driven up into the top wall.
        bus.sw = 1'b1;
        bus.up1 = 1'b1;
        bus.up2 = 1'b1;
        tick();
        chk_st("serve_enter", ST_SERVE);
        chk_pads("serve_enter", 208, 208);
        ticks(29);
        chk_st("serve_t30", ST_SERVE);
        chk_pads("serve_t30", 92, 92);
        chk_ball("serve_t30", 316, 236);
        ticks(30);
        chk_st("serve_t60", ST_SERVE);
        chk_pads("pad_top_sat", 0, 0);
        tick();
        chk_st("play_t61", ST_PLAY);
        chk_ball("play_t61", 316, 236);

        // Point 1: ball runs right, right paddle parked at the top misses it.
        bus.up1 = 1'b0;
        bus.down1 = 1'b1;
        tick();
        chk_ball("play_j1", 318, 238);
        chk_pads("play_j1", 4, 0);
        bus.sw = 1'b0;
        tick();
        chk_st("freeze", ST_PLAY);
        chk_ball("freeze", 318, 238);
        chk_pads("freeze", 4, 0);
        bus.sw = 1'b1;
        ticks(109);
        chk_pads("pad_bot_sat", 416, 0);
        chk_ball("play_j110", 536, 456);
        ticks(8);
        chk_ball("play_j118", 552, 472);
        tick();
        chk_ball("bottom_clamp", 554, 472);
        tick();
        chk_ball("bottom_reflect", 556, 470);
        ticks(37);
        chk_st("play_j157", ST_PLAY);
        chk_ball("play_j157", 630, 396);
        tick();
        chk_st("right_miss", ST_POINT);
        chk_ball("right_miss", 632, 394);
        chk_score("right_miss", 1, 0);
        bus.up2 = 1'b0;
        bus.down2 = 1'b1;
        tick();
        chk_st("point1_serve", ST_SERVE);
        chk_ball("point1_serve", 316, 236);

        // Point 2: right paddle at the bottom returns, left paddle at the bottom misses.
        ticks(60);
        chk_st("p2_play", ST_PLAY);
        chk_pads("p2_play", 416, 240);
        ticks(145);
        chk_ball("p2_k145", 606, 420);
        tick();
        chk_st("right_hit", ST_PLAY);
        chk_ball("right_hit", 608, 418);
        ticks(208);
        chk_ball("p2_k354", 192, 2);
        tick();
        chk_ball("top_touch", 190, 0);
        tick();
        chk_ball("top_clamp", 188, 0);
        tick();
        chk_ball("top_reflect", 186, 2);
        ticks(92);
        chk_ball("p2_k449", 2, 186);
        tick();
        chk_st("left_miss", ST_POINT);
        chk_ball("left_miss", 0, 188);
        chk_score("left_miss", 1, 1);
        bus.down2 = 1'b0;
        bus.up2 = 1'b1;
        tick();
        chk_st("point2_serve", ST_SERVE);

        // Point 3: serve goes left, left paddle returns it, right paddle misses.
        ticks(60);
        ticks(145);
        chk_ball("p3_k145", 26, 420);
        tick();
        chk_st("left_hit", ST_PLAY);
        chk_ball("left_hit", 24, 418);
        ticks(303);
        chk_ball("p3_k449", 630, 186);
        tick();
        chk_st("p3_point", ST_POINT);
        chk_ball("p3_point", 632, 188);
        chk_score("p3_point", 2, 1);
        tick();

        // Points 4..10: repeat of point 1 until player 1 reaches the winning score.
        for (int i = 3; i <= 9; i++) begin
            ticks(218);
            chk_st($sformatf("pt_s1_%0d", i), ST_POINT);
            chk($sformatf("pt_s1_%0d.score1", i), 32'(bus.score1), i);
            chk($sformatf("pt_s1_%0d.ball_x", i), 32'(bus.ball_x), 632);
            tick();
            chk_st($sformatf("after_pt_%0d", i), i == 9 ? ST_OVER : ST_SERVE);
        end
        chk("over.game_over", 32'(bus.game_over), 1);
        chk_score("over", 9, 1);
        chk_ball("over_hold", 632, 394);
        tick();
        chk_st("over_sw1", ST_OVER);
        bus.sw = 1'b0;
        tick();
        chk_reset("over_to_idle");

        // Asynchronous reset in the middle of a rally, sampled before any clock edge.
        bus.sw = 1'b1;
        bus.up1 = 1'b0;
        bus.down1 = 1'b0;
        bus.up2 = 1'b0;
        tick();
        chk_st("g2_serve", ST_SERVE);
        ticks(65);
        chk_st("g2_play", ST_PLAY);
        chk_ball("g2_play", 326, 246);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_st("post_reset_serve", ST_SERVE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
